mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port 16-bit unified memory between three requesters: CPU instruction
//  fetch (if_*), CPU data access (dm_*) and the external program loader (ld_*, write-only).
//  It sits between the cpu and the memory macro. Each requester holds its request until it
//  receives a one-cycle ack, so a stalled requester simply waits.
//  Supports multi-cycle memory latency through a wait-state counter.
// PARAMETERS
//  AW           16  address width
//  DW           16  data width
//  WAIT_CYCLES  1   memory access cycles per transaction; legal range 1..7, 0 = elaboration error
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request, level, held until if_ack
//  if_addr    in   AW  fetch address
//  if_rdata   out  DW  fetched instruction, valid with if_ack, held until next if_ack
//  if_ack     out  1   one-cycle fetch completion pulse
//  dm_req     in   1   data request, level, held until dm_ack
//  dm_we      in   1   1 = write, 0 = read
//  dm_addr    in   AW  data address
//  dm_wdata   in   DW  write data
//  dm_rdata   out  DW  read data, valid with dm_ack, held until next dm_ack
//  dm_ack     out  1   one-cycle data completion pulse
//  ld_req     in   1   loader write request, level, held until ld_ack
//  ld_addr    in   AW  loader address
//  ld_wdata   in   DW  loader write data
//  ld_ack     out  1   one-cycle loader completion pulse
//  mem_en     out  1   memory enable
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, sampled on the last ACCESS cycle
//  busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, wcnt=0, last_grant=IF.
//   All outputs 0, including the rdata registers. Takes effect immediately.
//  Reset mid-transaction: the access is abandoned and no ack is issued. Memory outputs drop
//   to 0 asynchronously.
//  FSM IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
//  IDLE: evaluate requests at the clock edge. Priority:
//   - ld_req wins.
//   - Otherwise, if dm_req and if_req are both high, grant whichever of {DM, IF} is not
//     last_grant. After reset, DM wins the first tie.
//   - Otherwise grant the single requester.
//   On a grant: latch addr, we, wdata (ld forces we=1; if forces we=0), set wcnt=WAIT_CYCLES-1,
//   update last_grant (DM/IF only), go to ACCESS. No request: stay in IDLE.
//  ACCESS: mem_en=1 and mem_addr/mem_we/mem_wdata are driven from the latched values, stable
//   for exactly WAIT_CYCLES cycles.
//   - wcnt decrements each cycle.
//   - When wcnt==0: on a read, capture mem_rdata into the granted port's rdata; go to RESP.
//  RESP: mem_en=0, mem_we=0. Pulse the granted port's ack for one cycle; go to IDLE.
//   Requests still high during RESP are ignored. The requester drops or changes its request
//   in the ack cycle.
//  Latency: request sampled at edge N -> ACCESS cycles N+1..N+WAIT_CYCLES -> ack in cycle
//   N+WAIT_CYCLES+1. Minimum occupancy is WAIT_CYCLES+2 cycles per transaction.
//  Ack and mem_en are never high in the same cycle. At most one ack is high in any cycle.
//  Request inputs are not checked for stability. Behaviour is undefined if addr/data change
//   while req is high before ack, but latched values are used throughout the access.
// TESTING
//  1 WAIT=1, if_req addr 0x0010, mem holds 0xA5A5 -> mem_en=1 one cycle with addr 0x0010, we=0;
//    next cycle if_ack=1, if_rdata=0xA5A5, busy low the cycle after.
//  2 WAIT=1, if_req 0x0002 and dm_req we=1 addr 0x8000 wdata 0x1234 in the same cycle ->
//    dm served first (mem_we=1, 0x8000/0x1234), dm_ack; then the fetch; if_ack 3 cycles after dm_ack.
//  3 dm_req and if_req held high continuously for 6 transactions -> grants alternate
//    DM,IF,DM,IF,DM,IF, with no starvation.
//  4 ld_req 0x0100/0xBEEF plus dm_req plus if_req -> loader first (mem_we=1), then DM, then IF.
//  5 rst pulled low during ACCESS with WAIT=3 -> all outputs 0 immediately, no ack; after release,
//    a re-held request completes normally.
//  6 WAIT=3, dm read of 0x0040 returning 0x0F0F -> mem_en high 3 cycles, dm_ack in the 4th cycle
//    after sampling, dm_rdata=0x0F0F.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port unified memory between three requesters: CPU
// instruction fetch (if_*), CPU data access (dm_*) and the external program
// loader (ld_*, write-only). Each requester holds a level request until it
// sees a one-cycle ack. Every transaction occupies the memory for WAIT_CYCLES
// cycles, followed by one response cycle that carries the ack.
//
// Ports
//    clk        rising-edge clock
//    rst        asynchronous, active-low reset
//    if_*       fetch port: req/addr in, rdata/ack out (read only)
//    dm_*       data port: req/we/addr/wdata in, rdata/ack out
//    ld_*       loader port: req/addr/wdata in, ack out (write only)
//    mem_*      memory macro side: en/we/addr/wdata out, rdata in
//    busy       high whenever the arbiter is not idle
//
// Parameters
//    AW, DW       address / data width
//    WAIT_CYCLES  memory access cycles per transaction, 1..7
// -----------------------------------------------------------------------------
// state   | meaning
// --------+--------------------------------------------------------------------
// IDLE    | no transaction; requests are arbitrated on every edge
// ACCESS  | memory driven from latched request for WAIT_CYCLES cycles
// RESP    | memory released; granted port's ack pulses for one cycle
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW          = 16,
   parameter int DW          = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,

   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ack,

   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_ack,

   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,

   output logic          busy
);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 7) begin : g_bad_wait
      $error("mem_arbiter: WAIT_CYCLES must be in 1..7");
   end

   localparam logic [2:0] WCNT_INIT = 3'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_DM   = 2'd2,
      GNT_LD   = 2'd3
   } gnt_t;

   state_t        state;
   gnt_t          gnt;
   logic [2:0]    wcnt;
   // 1 = DM was the most recent CPU-side grant, 0 = IF (reset value)
   logic          last_dm;

   gnt_t          nxt_gnt;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Loader has absolute priority; fetch and data alternate on a tie so
   // neither CPU port can starve the other.
   always_comb begin
      nxt_gnt = GNT_NONE;
      if (ld_req) begin
         nxt_gnt = GNT_LD;
      end else if (dm_req && if_req) begin
         nxt_gnt = last_dm ? GNT_IF : GNT_DM;
      end else if (dm_req) begin
         nxt_gnt = GNT_DM;
      end else if (if_req) begin
         nxt_gnt = GNT_IF;
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      case (nxt_gnt)
         GNT_LD: begin
            sel_we    = 1'b1;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
         end
         GNT_DM: begin
            sel_we    = dm_we;
            sel_addr  = dm_addr;
            sel_wdata = dm_wdata;
         end
         GNT_IF: begin
            sel_we    = 1'b0;
            sel_addr  = if_addr;
            sel_wdata = '0;
         end
         default: begin
            sel_we    = 1'b0;
            sel_addr  = '0;
            sel_wdata = '0;
         end
      endcase
   end

   // The mem_* registers double as the latched request: they are loaded on
   // the grant edge and held untouched for the whole ACCESS phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         gnt       <= GNT_NONE;
         wcnt      <= 3'd0;
         last_dm   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         ld_ack    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         ld_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (nxt_gnt != GNT_NONE) begin
                  state     <= ST_ACCESS;
                  gnt       <= nxt_gnt;
                  wcnt      <= WCNT_INIT;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  busy      <= 1'b1;
                  if (nxt_gnt == GNT_DM) begin
                     last_dm <= 1'b1;
                  end else if (nxt_gnt == GNT_IF) begin
                     last_dm <= 1'b0;
                  end
               end
            end

            ST_ACCESS: begin
               if (wcnt == 3'd0) begin
                  if (!mem_we) begin
                     if (gnt == GNT_IF) begin
                        if_rdata <= mem_rdata;
                     end else if (gnt == GNT_DM) begin
                        dm_rdata <= mem_rdata;
                     end
                  end
                  case (gnt)
                     GNT_IF:  if_ack <= 1'b1;
                     GNT_DM:  dm_ack <= 1'b1;
                     GNT_LD:  ld_ack <= 1'b1;
                     default: ;
                  endcase
                  state     <= ST_RESP;
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
               end else begin
                  wcnt <= wcnt - 3'd1;
               end
            end

            ST_RESP: begin
               state <= ST_IDLE;
               gnt   <= GNT_NONE;
               busy  <= 1'b0;
            end

            default: begin
               state     <= ST_IDLE;
               gnt       <= GNT_NONE;
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic clk;
   logic rst;

   // instance a: WAIT_CYCLES = 1
   logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack, a_ld_req, a_ld_ack;
   logic [15:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata, a_ld_addr, a_ld_wdata;
   logic        a_mem_en, a_mem_we, a_busy;
   logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

   // instance b: WAIT_CYCLES = 3
   logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack, b_ld_req, b_ld_ack;
   logic [15:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata, b_ld_addr, b_ld_wdata;
   logic        b_mem_en, b_mem_we, b_busy;
   logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

   int total = 0;
   int bad   = 0;
   int b_en_cnt;

   mem_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
      .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
      .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
      .ld_req(a_ld_req), .ld_addr(a_ld_addr), .ld_wdata(a_ld_wdata), .ld_ack(a_ld_ack),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   mem_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
      .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
      .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
      .ld_req(b_ld_req), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata), .ld_ack(b_ld_ack),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   function automatic logic [15:0] rdfn(input logic [15:0] addr);
      case (addr)
         16'h0010: rdfn = 16'hA5A5;
         16'h0040: rdfn = 16'h0F0F;
         16'h0002: rdfn = 16'h1357;
         default:  rdfn = addr ^ 16'h3C3C;
      endcase
   endfunction

   // Memory a answers whenever enabled; memory b only has valid data on the
   // third consecutive enabled cycle, so an early or late capture is visible.
   assign a_mem_rdata = a_mem_en ? rdfn(a_mem_addr) : 16'hDEAD;

   always @(posedge clk or negedge rst) begin
      if (!rst) b_en_cnt <= 0;
      else      b_en_cnt <= b_mem_en ? b_en_cnt + 1 : 0;
   end
   assign b_mem_rdata = (b_mem_en && b_en_cnt == 2) ? rdfn(b_mem_addr) : 16'hBAD0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 = timeout, 1 = IF, 2 = DM, 3 = LD, 4 = more than one ack
   task automatic wait_ack_a(output int which, output int cyc);
      bit done;
      which = 0; cyc = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         cyc++;
         if (a_if_ack || a_dm_ack || a_ld_ack) begin
            done = 1;
            if ($countones({a_if_ack, a_dm_ack, a_ld_ack}) > 1) which = 4;
            else if (a_if_ack) which = 1;
            else if (a_dm_ack) which = 2;
            else which = 3;
         end
      end
   endtask

   task automatic wait_ack_b(output int which, output int cyc);
      bit done;
      which = 0; cyc = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         cyc++;
         if (b_if_ack || b_dm_ack || b_ld_ack) begin
            done = 1;
            if ($countones({b_if_ack, b_dm_ack, b_ld_ack}) > 1) which = 4;
            else if (b_if_ack) which = 1;
            else if (b_dm_ack) which = 2;
            else which = 3;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      {a_if_req, a_dm_req, a_dm_we, a_ld_req} = '0;
      {a_if_addr, a_dm_addr, a_dm_wdata, a_ld_addr, a_ld_wdata} = '0;
      {b_if_req, b_dm_req, b_dm_we, b_ld_req} = '0;
      {b_if_addr, b_dm_addr, b_dm_wdata, b_ld_addr, b_ld_wdata} = '0;
      tick();
      tick();
      total++;
      if ({a_mem_en, a_mem_we, a_busy, a_if_ack, a_dm_ack, a_ld_ack} !== 6'b0) begin
         bad++; $display("FAIL reset_a_ctrl got=%b exp=000000",
                         {a_mem_en, a_mem_we, a_busy, a_if_ack, a_dm_ack, a_ld_ack});
      end
      total++;
      if ({a_mem_addr, a_mem_wdata, a_if_rdata, a_dm_rdata} !== 64'h0) begin
         bad++; $display("FAIL reset_a_data got=%h exp=0",
                         {a_mem_addr, a_mem_wdata, a_if_rdata, a_dm_rdata});
      end
      total++;
      if ({b_mem_en, b_busy, b_if_ack, b_dm_ack, b_ld_ack} !== 5'b0) begin
         bad++; $display("FAIL reset_b_ctrl got=%b exp=00000",
                         {b_mem_en, b_busy, b_if_ack, b_dm_ack, b_ld_ack});
      end
      rst = 1'b1;
      tick();
      total++;
      if (a_busy !== 1'b0 || a_mem_en !== 1'b0) begin
         bad++; $display("FAIL idle_no_req busy=%b mem_en=%b exp=0 0", a_busy, a_mem_en);
      end
   endtask

   task automatic test_single_fetch();
      a_if_req = 1'b1; a_if_addr = 16'h0010;
      tick();
      total++;
      if ({a_mem_en, a_mem_we, a_mem_addr, a_busy, a_if_ack} !== {1'b1, 1'b0, 16'h0010, 1'b1, 1'b0}) begin
         bad++; $display("FAIL fetch_access en=%b we=%b addr=%h busy=%b ack=%b exp=1 0 0010 1 0",
                         a_mem_en, a_mem_we, a_mem_addr, a_busy, a_if_ack);
      end
      tick();
      total++;
      if ({a_mem_en, a_if_ack, a_if_rdata} !== {1'b0, 1'b1, 16'hA5A5}) begin
         bad++; $display("FAIL fetch_ack en=%b ack=%b rdata=%h exp=0 1 a5a5",
                         a_mem_en, a_if_ack, a_if_rdata);
      end
      a_if_req = 1'b0;
      tick();
      total++;
      if ({a_busy, a_if_ack, a_if_rdata} !== {1'b0, 1'b0, 16'hA5A5}) begin
         bad++; $display("FAIL fetch_after busy=%b ack=%b rdata=%h exp=0 0 a5a5",
                         a_busy, a_if_ack, a_if_rdata);
      end
   endtask

   task automatic test_tie_after_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      a_if_req = 1'b1; a_if_addr = 16'h0002;
      a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 16'h8000; a_dm_wdata = 16'h1234;
      tick();
      total++;
      if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 16'h8000, 16'h1234}) begin
         bad++; $display("FAIL tie_dm_first en=%b we=%b addr=%h wdata=%h exp=1 1 8000 1234",
                         a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
      end
      tick();
      total++;
      if ({a_dm_ack, a_if_ack, a_mem_en} !== 3'b100) begin
         bad++; $display("FAIL tie_dm_ack got=%b exp=100", {a_dm_ack, a_if_ack, a_mem_en});
      end
      a_dm_req = 1'b0; a_dm_we = 1'b0;
      tick();
      tick();
      total++;
      if ({a_mem_en, a_mem_we, a_mem_addr} !== {1'b1, 1'b0, 16'h0002}) begin
         bad++; $display("FAIL tie_fetch_access en=%b we=%b addr=%h exp=1 0 0002",
                         a_mem_en, a_mem_we, a_mem_addr);
      end
      tick();
      total++;
      if ({a_if_ack, a_if_rdata} !== {1'b1, 16'h1357}) begin
         bad++; $display("FAIL tie_fetch_ack ack=%b rdata=%h exp=1 1357", a_if_ack, a_if_rdata);
      end
      a_if_req = 1'b0;
      tick();
   endtask

   task automatic test_alternate();
      int which, cyc, exp_which;
      a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 16'h0040;
      a_if_req = 1'b1; a_if_addr = 16'h0010;
      for (int i = 0; i < 6; i++) begin
         wait_ack_a(which, cyc);
         exp_which = (i % 2 == 0) ? 2 : 1;
         total++;
         if (which !== exp_which) begin
            bad++; $display("FAIL alt_grant_%0d got=%0d exp=%0d", i, which, exp_which);
         end
         if (i > 0) begin
            total++;
            if (cyc !== 3) begin
               bad++; $display("FAIL alt_spacing_%0d got=%0d exp=3", i, cyc);
            end
         end
      end
      total++;
      if ({a_if_rdata, a_dm_rdata} !== {16'hA5A5, 16'h0F0F}) begin
         bad++; $display("FAIL alt_rdata got=%h exp=a5a50f0f", {a_if_rdata, a_dm_rdata});
      end
      a_dm_req = 1'b0; a_if_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_loader_priority();
      int which, cyc;
      a_ld_req = 1'b1; a_ld_addr = 16'h0100; a_ld_wdata = 16'hBEEF;
      a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 16'h0040;
      a_if_req = 1'b1; a_if_addr = 16'h0010;
      tick();
      total++;
      if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 16'h0100, 16'hBEEF}) begin
         bad++; $display("FAIL ld_access en=%b we=%b addr=%h wdata=%h exp=1 1 0100 beef",
                         a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
      end
      wait_ack_a(which, cyc);
      total++;
      if (which !== 3) begin
         bad++; $display("FAIL ld_first got=%0d exp=3", which);
      end
      a_ld_req = 1'b0;
      wait_ack_a(which, cyc);
      total++;
      if (which !== 2) begin
         bad++; $display("FAIL ld_then_dm got=%0d exp=2", which);
      end
      a_dm_req = 1'b0;
      wait_ack_a(which, cyc);
      total++;
      if (which !== 1) begin
         bad++; $display("FAIL ld_then_if got=%0d exp=1", which);
      end
      a_if_req = 1'b0;
      tick();
   endtask

   task automatic test_wait3_read();
      b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 16'h0040;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if ({b_mem_en, b_mem_addr, b_dm_ack} !== {1'b1, 16'h0040, 1'b0}) begin
            bad++; $display("FAIL w3_access_%0d en=%b addr=%h ack=%b exp=1 0040 0",
                            k, b_mem_en, b_mem_addr, b_dm_ack);
         end
      end
      tick();
      total++;
      if ({b_mem_en, b_dm_ack, b_dm_rdata} !== {1'b0, 1'b1, 16'h0F0F}) begin
         bad++; $display("FAIL w3_ack en=%b ack=%b rdata=%h exp=0 1 0f0f",
                         b_mem_en, b_dm_ack, b_dm_rdata);
      end
      b_dm_req = 1'b0;
      tick();
      total++;
      if ({b_busy, b_dm_ack} !== 2'b00) begin
         bad++; $display("FAIL w3_idle busy=%b ack=%b exp=0 0", b_busy, b_dm_ack);
      end
   endtask

   task automatic test_reset_mid_access();
      int which, cyc;
      b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 16'h0010;
      tick();
      tick();
      total++;
      if (b_mem_en !== 1'b1) begin
         bad++; $display("FAIL rstmid_in_access got=%b exp=1", b_mem_en);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({b_mem_en, b_mem_addr, b_busy, b_dm_ack, b_dm_rdata} !== {1'b0, 16'h0, 1'b0, 1'b0, 16'h0}) begin
         bad++; $display("FAIL rstmid_async en=%b addr=%h busy=%b ack=%b rdata=%h exp=0 0000 0 0 0000",
                         b_mem_en, b_mem_addr, b_busy, b_dm_ack, b_dm_rdata);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if ({b_dm_ack, b_mem_en, b_busy} !== 3'b000) begin
            bad++; $display("FAIL rstmid_hold_%0d got=%b exp=000", k, {b_dm_ack, b_mem_en, b_busy});
         end
      end
      rst = 1'b1;
      wait_ack_b(which, cyc);
      total++;
      if (which !== 2 || cyc !== 4) begin
         bad++; $display("FAIL rstmid_retry which=%0d cyc=%0d exp=2 4", which, cyc);
      end
      total++;
      if (b_dm_rdata !== 16'hA5A5) begin
         bad++; $display("FAIL rstmid_rdata got=%h exp=a5a5", b_dm_rdata);
      end
      b_dm_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_tie_after_reset();
      test_alternate();
      test_loader_priority();
      test_wait3_read();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Protocol invariants on every cycle outside reset.
   always @(negedge clk) begin
      if (rst) begin
         if ((a_mem_en && (a_if_ack || a_dm_ack || a_ld_ack)) ||
             $countones({a_if_ack, a_dm_ack, a_ld_ack}) > 1) begin
            bad++; $display("FAIL inv_a en=%b acks=%b", a_mem_en, {a_if_ack, a_dm_ack, a_ld_ack});
         end
         if ((b_mem_en && (b_if_ack || b_dm_ack || b_ld_ack)) ||
             $countones({b_if_ack, b_dm_ack, b_ld_ack}) > 1) begin
            bad++; $display("FAIL inv_b en=%b acks=%b", b_mem_en, {b_if_ack, b_dm_ack, b_ld_ack});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

endmodule
